// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 raster constants, RGB332 colours and tile state codes.
package vga_pkg;
  localparam logic [9:0] H_LAST = 10'd799;
  localparam logic [9:0] V_LAST = 10'd520;
  localparam logic [9:0] HPULSE = 10'd96;
  localparam logic [9:0] HBP    = 10'd144;
  localparam logic [9:0] HFP    = 10'd784;
  localparam logic [9:0] VPULSE = 10'd2;
  localparam logic [9:0] VBP    = 10'd31;
  localparam logic [9:0] VFP    = 10'd511;

  localparam logic [7:0] BLACK  = 8'h00;
  localparam logic [7:0] YELLOW = 8'hFC;
  localparam logic [7:0] GREEN  = 8'h1C;

  typedef enum logic [1:0] {
    ST_HIDDEN = 2'b00,
    ST_SEL    = 2'b01,
    ST_SHOWN  = 2'b10,
    ST_DONE   = 2'b11
  } tile_state_e;
endpackage

// File: rtl/vga_timing.sv
// Free-running 800x521 raster counters with raw (undelayed) sync, active flag
// and a frame pulse; shared by every screen built on this raster.
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [9:0] hc_o,
  output logic [9:0] vc_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       active_o,
  output logic       frame_start_o
);
  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;

  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign hc_o     = hc_q;
  assign vc_o     = vc_q;
  assign hsync_o  = (hc_q >= HPULSE);
  assign vsync_o  = (vc_q >= VPULSE);
  assign active_o = (hc_q >= HBP) && (hc_q < HFP) && (vc_q >= VBP) && (vc_q < VFP);
  // Counters sit at zero throughout reset, so the pulse must be masked there.
  assign frame_start_o = (hc_q == '0) && (vc_q == '0) && !rst_i;
endmodule

// File: rtl/vga_tile_grid.sv
// ROWS x COLS tile renderer on the 640x480 raster: frame-shadowed inputs,
// frame-locked blink, 2-stage pixel pipeline with matched sync delay, win banner.
module vga_tile_grid
  import vga_pkg::*;
#(
  parameter int unsigned COLS         = 4,
  parameter int unsigned ROWS         = 2,
  parameter int unsigned N_TILES      = COLS * ROWS,
  parameter int unsigned TILE_W       = 80,
  parameter int unsigned TILE_H       = 144,
  parameter int unsigned PITCH_X      = 160,
  parameter int unsigned PITCH_Y      = 192,
  parameter int unsigned ORG_X        = 40,
  parameter int unsigned ORG_Y        = 72,
  parameter int unsigned BLINK_FRAMES = 15,
  parameter logic [7:0]  HIDDEN_RGB   = YELLOW,
  parameter logic [7:0]  WIN_RGB      = GREEN,
  parameter int unsigned WIN_X0       = 96,
  parameter int unsigned WIN_X1       = 544,
  parameter int unsigned WIN_Y0       = 72,
  parameter int unsigned WIN_Y1       = 408
) (
  input  logic                   clk25MHz,
  input  logic                   rst,
  input  logic [2*N_TILES-1:0]   tile_state,
  input  logic [8*N_TILES-1:0]   tile_rgb,
  input  logic                   winscreen,
  output logic [2:0]             red,
  output logic [2:0]             green,
  output logic [1:0]             blue,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_start,
  output logic                   blink_phase
);
  localparam logic [9:0]  X_START    = 10'(HBP + ORG_X - 1);
  localparam logic [9:0]  Y_START    = 10'(VBP + ORG_Y - 1);
  localparam logic [9:0]  PX_LAST    = 10'(PITCH_X - 1);
  localparam logic [9:0]  PY_LAST    = 10'(PITCH_Y - 1);
  localparam logic [9:0]  TW_C       = 10'(TILE_W);
  localparam logic [9:0]  TH_C       = 10'(TILE_H);
  localparam logic [3:0]  COLS_C     = 4'(COLS);
  localparam logic [3:0]  ROWS_C     = 4'(ROWS);
  localparam logic [9:0]  BAN_X0     = 10'(HBP + WIN_X0);
  localparam logic [9:0]  BAN_X1     = 10'(HBP + WIN_X1);
  localparam logic [9:0]  BAN_Y0     = 10'(VBP + WIN_Y0);
  localparam logic [9:0]  BAN_Y1     = 10'(VBP + WIN_Y1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

  logic [9:0] hc, vc;
  logic       hs_raw, vs_raw, active;

  vga_timing u_timing (
    .clk_i         (clk25MHz),
    .rst_i         (rst),
    .hc_o          (hc),
    .vc_o          (vc),
    .hsync_o       (hs_raw),
    .vsync_o       (vs_raw),
    .active_o      (active),
    .frame_start_o (frame_start)
  );

  logic                 xv_q, xv_d, yv_q, yv_d;
  logic [9:0]           x_q, x_d, y_q, y_d;
  logic [3:0]           col_q, col_d, row_q, row_d;
  logic                 hit, banner;
  logic                 s1_act_q, s1_hit_q, s1_ban_q;
  logic [3:0]           s1_col_q, s1_row_q;
  logic [1:0]           hs_dly_q, vs_dly_q;
  logic [2*N_TILES-1:0] st_sh_q;
  logic [8*N_TILES-1:0] rgb_sh_q;
  logic                 win_sh_q;
  logic [15:0]          blink_cnt_q;
  logic                 blink_q;
  tile_state_e          tile_st;
  logic [7:0]           tile_face, rgb_d, rgb_q;

  // Position counters track (hc,vc) relative to the tile origin; x/y are the
  // offset inside the current pitch, col/row saturate at COLS/ROWS.
  always_comb begin
    xv_d = xv_q; x_d = x_q; col_d = col_q;
    yv_d = yv_q; y_d = y_q; row_d = row_q;
    if (hc == X_START) begin
      xv_d = 1'b1; x_d = '0; col_d = '0;
    end else if (hc == H_LAST) begin
      xv_d = 1'b0;
    end else if (xv_q) begin
      if (x_q == PX_LAST) begin
        x_d = '0;
        if (col_q < COLS_C) col_d = col_q + 4'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    if (hc == H_LAST) begin
      if (vc == Y_START) begin
        yv_d = 1'b1; y_d = '0; row_d = '0;
      end else if (vc == V_LAST) begin
        yv_d = 1'b0;
      end else if (yv_q) begin
        if (y_q == PY_LAST) begin
          y_d = '0;
          if (row_q < ROWS_C) row_d = row_q + 4'd1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end
    end
  end

  assign hit = xv_q && (x_q < TW_C) && (col_q < COLS_C) &&
               yv_q && (y_q < TH_C) && (row_q < ROWS_C);
  assign banner = (hc >= BAN_X0) && (hc < BAN_X1) && (vc >= BAN_Y0) && (vc < BAN_Y1);

  always_comb begin
    tile_st   = ST_HIDDEN;
    tile_face = BLACK;
    for (int unsigned r = 0; r < ROWS; r++)
      for (int unsigned c = 0; c < COLS; c++)
        if (s1_row_q == 4'(r) && s1_col_q == 4'(c)) begin
          tile_st   = tile_state_e'(st_sh_q[2*(r*COLS+c) +: 2]);
          tile_face = rgb_sh_q[8*(r*COLS+c) +: 8];
        end
    rgb_d = BLACK;
    if (s1_act_q) begin
      if (win_sh_q) begin
        rgb_d = s1_ban_q ? WIN_RGB : BLACK;
      end else if (s1_hit_q) begin
        case (tile_st)
          ST_HIDDEN: rgb_d = HIDDEN_RGB;
          ST_SEL:    rgb_d = blink_q ? HIDDEN_RGB : BLACK;
          ST_SHOWN:  rgb_d = tile_face;
          ST_DONE:   rgb_d = BLACK;
        endcase
      end
    end
  end

  always_ff @(posedge clk25MHz) begin
    if (rst) begin
      xv_q <= 1'b0; x_q <= '0; col_q <= '0;
      yv_q <= 1'b0; y_q <= '0; row_q <= '0;
      s1_act_q <= 1'b0; s1_hit_q <= 1'b0; s1_ban_q <= 1'b0;
      s1_col_q <= '0; s1_row_q <= '0;
      hs_dly_q <= '0; vs_dly_q <= '0;
      rgb_q <= '0;
      st_sh_q <= '0; rgb_sh_q <= '0; win_sh_q <= 1'b0;
      blink_cnt_q <= '0; blink_q <= 1'b1;
    end else begin
      xv_q <= xv_d; x_q <= x_d; col_q <= col_d;
      yv_q <= yv_d; y_q <= y_d; row_q <= row_d;
      s1_act_q <= active; s1_hit_q <= hit; s1_ban_q <= banner;
      s1_col_q <= col_q; s1_row_q <= row_q;
      hs_dly_q <= {hs_dly_q[0], hs_raw};
      vs_dly_q <= {vs_dly_q[0], vs_raw};
      rgb_q <= rgb_d;
      if (frame_start) begin
        st_sh_q  <= tile_state;
        rgb_sh_q <= tile_rgb;
        win_sh_q <= winscreen;
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_q <= '0;
          blink_q     <= ~blink_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 16'd1;
        end
      end
    end
  end

  assign {red, green, blue} = rgb_q;
  assign hsync       = hs_dly_q[1];
  assign vsync       = vs_dly_q[1];
  assign blink_phase = blink_q;
endmodule
